// File: rtl/led_scan_ctrl.sv
// Multiplexed LED matrix row scanner: fetches each row from the frame buffer,
// blanks the row drivers, then lights the row for a fixed number of cycles.
module led_scan_ctrl #(
  parameter int DATA_W    = 16,
  parameter int BLANK_CYC = 16,
  parameter int ON_CYC    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [4:0]        last_row,
  output logic              rd_req,
  output logic [4:0]        rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [4:0]        row_idx,
  output logic              row_oe,
  output logic [DATA_W-1:0] seg_data,
  output logic              frame_start,
  output logic [1:0]        dbg_state
);

  // Read handshake: a request is open while rd_req=1 and completes on the
  // first rising edge where rd_valid=1; rd_valid is ignored while rd_req=0.

  typedef enum logic [1:0] {IDLE, FETCH, BLANK, SHOW} state_t;

  localparam logic [15:0] BLANK_END = 16'(BLANK_CYC);
  localparam logic [15:0] ON_END    = 16'(ON_CYC - 1);

  state_t      state;
  logic [4:0]  row_cnt;
  logic [15:0] cyc_cnt;
  logic [4:0]  next_row;

  // last_row only matters here, so it is effectively sampled at row advance.
  assign next_row  = (row_cnt >= last_row) ? 5'd0 : row_cnt + 5'd1;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row_cnt     <= 5'd0;
      cyc_cnt     <= 16'd0;
      rd_req      <= 1'b0;
      rd_addr     <= 5'd0;
      row_idx     <= 5'd0;
      row_oe      <= 1'b0;
      seg_data    <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      row_cnt     <= 5'd0;
      cyc_cnt     <= 16'd0;
      rd_req      <= 1'b0;
      row_oe      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          state   <= FETCH;
          rd_req  <= 1'b1;
          rd_addr <= row_cnt;
        end
        FETCH: begin
          if (rd_valid) begin
            state    <= BLANK;
            rd_req   <= 1'b0;
            row_idx  <= rd_addr;
            seg_data <= rd_data;
            cyc_cnt  <= 16'd0;
          end
        end
        // The first BLANK cycle is the load cycle where the new row settles on
        // the drivers; BLANK_CYC dark cycles follow before the row is lit.
        BLANK: begin
          if (cyc_cnt == BLANK_END) begin
            state       <= SHOW;
            cyc_cnt     <= 16'd0;
            row_oe      <= 1'b1;
            frame_start <= (row_idx == 5'd0);
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        SHOW: begin
          if (cyc_cnt == ON_END) begin
            state   <= FETCH;
            cyc_cnt <= 16'd0;
            row_oe  <= 1'b0;
            row_cnt <= next_row;
            rd_addr <= next_row;
            rd_req  <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomised bench for led_scan_ctrl: a frame-buffer responder predicts each
// row shown, and a display monitor checks every lit row against that queue.
module tb_led_scan_ctrl;
  localparam int W = 16;
  localparam int B = 2;
  localparam int O = 4;

  logic         clk;
  logic         rst_main, rst_drv, rst;
  logic         enable;
  logic [4:0]   last_row;
  logic         rd_req;
  logic [4:0]   rd_addr;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic [4:0]   row_idx;
  logic         row_oe;
  logic [W-1:0] seg_data;
  logic         frame_start;
  logic [1:0]   dbg_state;

  assign rst = rst_main | rst_drv;

  led_scan_ctrl #(.DATA_W(W), .BLANK_CYC(B), .ON_CYC(O)) dut (
    .clk(clk), .rst(rst), .enable(enable), .last_row(last_row),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .row_idx(row_idx), .row_oe(row_oe), .seg_data(seg_data),
    .frame_start(frame_start), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // {completion cycle[52:21], row[20:16], data[15:0]}
  logic [52:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame buffer responder + row model ----------------
  int         max_delay = 0;
  bit         spurious = 0;
  bit         stall_arm = 0, stall_used = 0, stall_active = 0;
  bit         rst_on_valid = 0, rst_used = 0, rst_hit = 0;
  int         rst_drv_hold = 0;
  int         stall_seen = 0, stall_bad = 0;
  int         wait_cnt = 0;
  bit         in_req = 0;
  bit         model_first = 1;
  logic [4:0] model_row = '0;
  logic [4:0] exp_addr;

  initial begin
    rst_drv  = 1'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
  end

  always @(negedge clk) begin
    if (rst_drv_hold > 0) begin
      rst_drv_hold--;
      if (rst_drv_hold == 0) rst_drv = 1'b0;
    end
    if (rst || !enable) model_first = 1;
    if (rd_req && !rst) begin
      if (!in_req) begin
        in_req   = 1;
        exp_addr = model_first ? 5'd0 : ((model_row >= last_row) ? 5'd0 : model_row + 5'd1);
        model_row   = exp_addr;
        model_first = 0;
        check("rd_addr", 32'(rd_addr), 32'(exp_addr));
        if (stall_arm && !stall_used && exp_addr == 5'd2) begin
          wait_cnt     = 50;
          stall_active = 1;
          stall_used   = 1;
        end else begin
          wait_cnt = $urandom_range(max_delay, 0);
        end
      end
      if (wait_cnt == 0) begin
        rd_valid = 1'b1;
        rd_data  = stall_active ? 16'hA5A5 : 16'($urandom);
        if (rst_on_valid && !rst_used) begin
          rst_used     = 1;
          rst_hit      = 1;
          rst_drv      = 1'b1;
          rst_drv_hold = 2;
        end else begin
          exp_q.push_back({32'(cyc + 1), model_row, rd_data});
        end
        if (stall_active) begin
          check("stall_cycles", 32'(stall_seen), 32'd50);
          check("stall_hold", 32'(stall_bad), 32'd0);
          stall_active = 0;
        end
      end else begin
        rd_valid = 1'b0;
        wait_cnt--;
        if (stall_active) begin
          stall_seen++;
          if (rd_addr != 5'd2 || row_oe) stall_bad++;
        end
      end
    end else begin
      in_req   = 0;
      rd_valid = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
      rd_data  = 16'($urandom);
    end
  end

  // ---------------- display monitor ----------------
  int          show_cnt = 0;
  bit          period_check = 0, have_rise = 0;
  int          last_rise = 0;
  int          on_len = 0, show_bad = 0, stray_fs = 0, overlap = 0;
  bit          prev_oe = 0;
  logic [4:0]  cap_row;
  logic [W-1:0] cap_seg;
  logic [52:0] mon_e;

  always @(negedge clk) begin
    if (rst || !enable) have_rise = 0;
    if (row_oe && !prev_oe) begin
      show_cnt++;
      if (exp_q.size() == 0) begin
        check("show_without_fetch", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("row_idx", 32'(row_idx), 32'(mon_e[20:16]));
        check("seg_data", 32'(seg_data), 32'(mon_e[15:0]));
        check("frame_start", 32'(frame_start), 32'(mon_e[20:16] == 5'd0));
        check("blank_gap", 32'(cyc) - mon_e[52:21], 32'(B + 1));
      end
      if (period_check && have_rise) check("row_period", 32'(cyc - last_rise), 32'(2 + B + O));
      last_rise = cyc;
      have_rise = 1;
      cap_row   = row_idx;
      cap_seg   = seg_data;
      on_len    = 1;
      show_bad  = 0;
    end else if (row_oe) begin
      on_len++;
      if (row_idx != cap_row || seg_data != cap_seg || frame_start) show_bad++;
    end else if (prev_oe) begin
      if (enable && !rst) check("on_len", 32'(on_len), 32'(O));
      check("show_stable", 32'(show_bad), 32'd0);
    end
    if (frame_start && !row_oe) stray_fs++;
    if (rd_req && row_oe) overlap++;
    prev_oe = row_oe;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_shows(input int n);
    int target;
    int t;
    target = show_cnt + n;
    t = 0;
    while (show_cnt < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (show_cnt < target) check("show_timeout", 32'(show_cnt), 32'(target));
  endtask

  task automatic wait_show_row(input int r);
    int t;
    t = 0;
    @(negedge clk);
    while (!(row_oe && (r < 0 || int'(row_idx) == r)) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("row_wait_timeout", 32'(row_idx), 32'(r));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    check({tag, "_row_oe"}, 32'(row_oe), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_row_idx"}, 32'(row_idx), 32'd0);
    check({tag, "_seg_data"}, 32'(seg_data), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0]   hold_row;
    logic [W-1:0] hold_seg;
    int t;
    rst_main = 1'b1;
    enable   = 1'b0;
    last_row = 5'd3;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_main = 1'b0;
    @(negedge clk);

    // basic scan 0..3 with single-cycle fetches
    period_check = 1;
    enable = 1'b1;
    wait_shows(6);
    period_check = 0;

    // random fetch latency and stray rd_valid while idle
    max_delay = 5;
    spurious  = 1;
    wait_shows(8);

    // long stall on row 2
    stall_arm = 1;
    t = 0;
    while (!(stall_used && !stall_active) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("stall_timeout", 32'(stall_used), 32'd1);
    stall_arm = 0;
    wait_shows(2);

    // shrink last_row below the row being shown
    wait_show_row(-1);
    last_row = 5'd7;
    wait_show_row(5);
    last_row = 5'd2;
    wait_shows(3);

    // drop enable mid-show, then restart from row 0
    wait_show_row(-1);
    hold_row = row_idx;
    hold_seg = seg_data;
    enable = 1'b0;
    @(negedge clk);
    check("dis_row_oe", 32'(row_oe), 32'd0);
    check("dis_rd_req", 32'(rd_req), 32'd0);
    check("dis_row_idx", 32'(row_idx), 32'(hold_row));
    check("dis_seg_data", 32'(seg_data), 32'(hold_seg));
    repeat (4) @(negedge clk);
    check("idle_rd_req", 32'(rd_req), 32'd0);
    enable = 1'b1;
    wait_shows(2);

    // reset on the cycle a read completes
    rst_on_valid = 1;
    t = 0;
    while (!rst_hit && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!rst_hit) check("rst_hit_timeout", 32'(rst_hit), 32'd1);
    @(negedge clk);
    check_reset_outputs("midfetch_rst");
    rst_on_valid = 0;
    repeat (3) @(negedge clk);
    wait_shows(2);

    // single-row scan
    max_delay = 0;
    spurious  = 0;
    wait_show_row(-1);
    last_row = 5'd0;
    wait_shows(2);
    period_check = 1;
    wait_shows(4);
    period_check = 0;

    // wind down mid-show so no fetched row is left unshown
    wait_show_row(-1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("leftover_rows", 32'(exp_q.size()), 32'd0);
    check("stray_frame_start", 32'(stray_fs), 32'd0);
    check("req_while_lit", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of per-row segment/column data.
REQ-002 SHALL have parameter BLANK_CYC, default 16: blanking cycles before each row is shown; legal range 1..65535.
REQ-003 SHALL have parameter ON_CYC, default 1000: display cycles per row; legal range 1..65535.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: run scanning while high.
REQ-007 SHALL have port last_row, input, 5: highest row index scanned (rows 0..last_row).
REQ-008 SHALL have port rd_req, output, 1: row-data read request to the frame buffer.
REQ-009 SHALL have port rd_addr, output, 5: row index being read.
REQ-010 SHALL have port rd_valid, input, 1: read data valid, completing the request.
REQ-011 SHALL have port rd_data, input, DATA_W: row data.
REQ-012 SHALL have port row_idx, output, 5: active row index, driving the 5-to-32 row decoder.
REQ-013 SHALL have port row_oe, output, 1: row output enable; high only while the row is lit.
REQ-014 SHALL have port seg_data, output, DATA_W: column data for row_idx.
REQ-015 SHALL have port frame_start, output, 1: one-cycle pulse at the start of each frame.

Function
REQ-016 SHALL implement the states IDLE, FETCH, BLANK and SHOW; all outputs SHALL be registered.
REQ-017 IDLE: when enable is sampled high, the next state SHALL be FETCH with rd_addr = scan row counter (0 after reset).
REQ-018 FETCH: rd_req SHALL be 1; rd_addr SHALL be held stable until completion; row_oe SHALL be 0.
REQ-019 A read SHALL complete on a cycle with rd_req=1 and rd_valid=1; rd_valid SHALL be ignored while rd_req=0.
REQ-020 On completion, the next cycle SHALL have rd_req=0, row_idx=rd_addr, seg_data=rd_data, and state BLANK.
REQ-021 BLANK: row_oe SHALL be 0 for exactly BLANK_CYC cycles, then the state SHALL be SHOW.
REQ-022 SHOW: row_oe SHALL be 1 for exactly ON_CYC cycles; row_idx and seg_data SHALL remain stable.
REQ-023 At the end of SHOW, the row counter SHALL advance as (row >= last_row) ? 0 : row+1, and the state SHALL return to FETCH.
REQ-024 last_row SHALL be sampled only at row advance; a decrease below the current row SHALL wrap to 0 at the next advance.
REQ-025 frame_start SHALL pulse for 1 cycle on the first SHOW cycle of row 0.
REQ-026 last_row=0 SHALL repeatedly scan row 0, with frame_start on every row period.
REQ-027 enable sampled low in any state SHALL cause, next cycle: state IDLE, rd_req=0, row_oe=0, row counter=0; seg_data and row_idx SHALL hold.
REQ-028 An unbounded rd_valid stall SHALL keep the block in FETCH with row_oe=0 (display dark, no ghosting).
REQ-029 Row period SHALL be (fetch latency + 1) + BLANK_CYC + ON_CYC cycles, where fetch latency is the number of FETCH cycles including the completing cycle.

Reset
REQ-030 rst SHALL force, next cycle: state IDLE; row_idx=0, rd_addr=0, row counter=0, seg_data=0; rd_req=0, row_oe=0, frame_start=0; cycle counters=0.
REQ-031 rst SHALL take priority over enable and rd_valid, including mid-FETCH and mid-SHOW.

Verification
REQ-032 BLANK_CYC=2, ON_CYC=4, last_row=3, rd_valid=1 one cycle after each rd_req -> row_idx sequence 0,1,2,3,0; row_oe high exactly 4 cycles per row, low 2 cycles before each; frame_start every 4 rows.
REQ-033 Hold rd_valid=0 for 50 cycles in FETCH of row 2 -> rd_req=1 and rd_addr=2 held for all 50 cycles, row_oe=0; rd_data=16'hA5A5 then appears on seg_data.
REQ-034 last_row changed 7->2 while showing row 5 -> next row is 0; frame_start pulses.
REQ-035 enable dropped during SHOW -> next cycle row_oe=0, rd_req=0; re-enable -> fetch of rd_addr=0.
REQ-036 rst asserted during FETCH with rd_valid=1 on the same cycle -> data not latched; all outputs at reset values next cycle.
REQ-037 last_row=0 -> row_idx constant 0; frame_start once per row period of (2 + BLANK_CYC + ON_CYC) cycles with 1-cycle fetch.
